// File: rtl/flash_boot_ctrl.sv
// flash_boot_ctrl: one-shot SPI flash boot loader.
// After the management hold drops it issues a single READ (0x03) to the
// external flash, pulls a 12-byte boot record and applies it to the user
// GPIO values/enables and the user-project enable.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for boot_hold to drop, flash deselected
// S_XFER  | 128 SPI bit-slots: cmd, 24-bit address, 96 data bits
// S_CHECK | one cycle: validate magic byte, load GPIO/en registers
// S_DONE  | terminal, outputs held until the next reset
module flash_boot_ctrl #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [23:0] BOOT_ADDR = 24'h000000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        boot_hold,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1,
    output logic [37:0] gpio_out,
    output logic [37:0] gpio_oeb,
    output logic        en,
    output logic        boot_done,
    output logic        boot_err
);

    localparam int unsigned      DIV_W          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD       = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       CMD_READ       = 8'h03;
    localparam logic [7:0]       MAGIC          = 8'hA5;
    localparam logic [6:0]       FIRST_DATA_BIT = 7'd32;
    localparam logic [6:0]       LAST_BIT       = 7'd127;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [6:0]       bit_q, bit_d;
    logic [31:0]      tx_q, tx_d;
    logic [95:0]      rx_q, rx_d;
    logic             csb_q, csb_d;
    logic             sclk_q, sclk_d;
    logic             io0_q, io0_d;
    logic [37:0]      gpio_out_q, gpio_out_d;
    logic [37:0]      gpio_oeb_q, gpio_oeb_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Record byte Bk sits at rx_q[95-8k -: 8] once all 96 bits are shifted in.
    logic [7:0] rec_b0;
    logic [37:0] rec_gpio_out;
    logic [37:0] rec_gpio_oeb;
    logic unused_rec_bits;

    assign rec_b0       = rx_q[95:88];
    assign rec_gpio_out = {rx_q[53:48], rx_q[63:56], rx_q[71:64], rx_q[79:72], rx_q[87:80]};
    assign rec_gpio_oeb = {rx_q[13:8], rx_q[23:16], rx_q[31:24], rx_q[39:32], rx_q[47:40]};
    // Reserved record bits: B5[7:6], B10[7:6], B11[7:1].
    assign unused_rec_bits = ^{rx_q[55:54], rx_q[15:14], rx_q[7:1]};

    // Next-state, SPI shifter and boot-result logic.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        csb_d      = csb_q;
        sclk_d     = sclk_q;
        io0_d      = io0_q;
        gpio_out_d = gpio_out_q;
        gpio_oeb_d = gpio_oeb_q;
        en_d       = en_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (!boot_hold) begin
                    state_d = S_XFER;
                    csb_d   = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = DIV_LOAD;
                    bit_d   = '0;
                    // Bit 0 goes straight onto MOSI; the rest is pre-shifted.
                    io0_d   = CMD_READ[7];
                    tx_d    = {CMD_READ[6:0], BOOT_ADDR, 1'b0};
                end
            end

            S_XFER: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    div_d = DIV_LOAD;
                    if (!sclk_q) begin
                        // Rising edge: MISO was launched on the previous fall.
                        sclk_d = 1'b1;
                        if (bit_q >= FIRST_DATA_BIT) begin
                            rx_d = {rx_q[94:0], flash_io1};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            csb_d   = 1'b1;
                            io0_d   = 1'b0;
                            state_d = S_CHECK;
                        end else begin
                            // tx_q drains to zeros, so data slots drive MOSI low.
                            bit_d = bit_q + 7'd1;
                            io0_d = tx_q[31];
                            tx_d  = {tx_q[30:0], 1'b0};
                        end
                    end
                end
            end

            S_CHECK: begin
                done_d  = 1'b1;
                state_d = S_DONE;
                if (rec_b0 == MAGIC) begin
                    gpio_out_d = rec_gpio_out;
                    gpio_oeb_d = rec_gpio_oeb;
                    en_d       = rx_q[0];
                end else begin
                    err_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            csb_q      <= 1'b1;
            sclk_q     <= 1'b0;
            io0_q      <= 1'b0;
            gpio_out_q <= '0;
            gpio_oeb_q <= '1;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            csb_q      <= csb_d;
            sclk_q     <= sclk_d;
            io0_q      <= io0_d;
            gpio_out_q <= gpio_out_d;
            gpio_oeb_q <= gpio_oeb_d;
            en_q       <= en_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign flash_csb = csb_q;
    assign flash_clk = sclk_q;
    assign flash_io0 = io0_q;
    assign gpio_out  = gpio_out_q;
    assign gpio_oeb  = gpio_oeb_q;
    assign en        = en_q;
    assign boot_done = done_q;
    assign boot_err  = err_q;

endmodule

// File: tb/tb_flash_boot_ctrl.sv
// Bench for flash_boot_ctrl: two instances (CLK_DIV=2 at address 0, and
// CLK_DIV=1 at a non-zero address), each with a small SPI flash model.
// Stimulus queues the expected boot result; a monitor pops and compares
// whenever an instance raises boot_done.
module tb_flash_boot_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetb_a, hold_a, resetb_b, hold_b;
    logic        csb_a, sclk_a, mosi_a, csb_b, sclk_b, mosi_b;
    logic        miso_a = 1'b0;
    logic        miso_b = 1'b0;
    logic [37:0] gout_a, goeb_a, gout_b, goeb_b;
    logic        en_a, done_a, err_a, en_b, done_b, err_b;
    logic [95:0] img_a, img_b;

    localparam logic [95:0] IMG_GOOD = 96'hA5AA_AAAA_AA2A_0000_0000_0001;
    localparam logic [95:0] IMG_BAD  = 96'h5AAA_AAAA_AA2A_0000_0000_0001;
    localparam logic [95:0] IMG_B    = 96'hA501_2345_67FF_0FF0_00FF_C3FE;

    flash_boot_ctrl #(.CLK_DIV(2), .BOOT_ADDR(24'h000000)) u_dut_a (
        .clock(clock), .resetb(resetb_a), .boot_hold(hold_a),
        .flash_csb(csb_a), .flash_clk(sclk_a), .flash_io0(mosi_a), .flash_io1(miso_a),
        .gpio_out(gout_a), .gpio_oeb(goeb_a), .en(en_a),
        .boot_done(done_a), .boot_err(err_a)
    );

    flash_boot_ctrl #(.CLK_DIV(1), .BOOT_ADDR(24'h123456)) u_dut_b (
        .clock(clock), .resetb(resetb_b), .boot_hold(hold_b),
        .flash_csb(csb_b), .flash_clk(sclk_b), .flash_io0(mosi_b), .flash_io1(miso_b),
        .gpio_out(gout_b), .gpio_oeb(goeb_b), .en(en_b),
        .boot_done(done_b), .boot_err(err_b)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Flash model A: count rising edges, capture header, launch MISO on falls.
    int          rise_a = 0;
    logic [31:0] hdr_a  = '0;
    always @(negedge csb_a or posedge sclk_a) begin
        if (!csb_a && sclk_a) begin
            if (rise_a < 32) hdr_a <= {hdr_a[30:0], mosi_a};
            rise_a <= rise_a + 1;
        end else if (!csb_a) begin
            rise_a <= 0;
            hdr_a  <= '0;
        end
    end
    always @(negedge sclk_a)
        if (!csb_a && rise_a >= 32 && rise_a < 128) miso_a <= img_a[127 - rise_a];

    // Flash model B.
    int          rise_b = 0;
    logic [31:0] hdr_b  = '0;
    always @(negedge csb_b or posedge sclk_b) begin
        if (!csb_b && sclk_b) begin
            if (rise_b < 32) hdr_b <= {hdr_b[30:0], mosi_b};
            rise_b <= rise_b + 1;
        end else if (!csb_b) begin
            rise_b <= 0;
            hdr_b  <= '0;
        end
    end
    always @(negedge sclk_b)
        if (!csb_b && rise_b >= 32 && rise_b < 128) miso_b <= img_b[127 - rise_b];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          side;
        int          lat;
        logic [37:0] gout;
        logic [37:0] goeb;
        logic        en;
        logic        err;
        int          edges;
        logic [31:0] hdr;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input int side, input int lat, input logic [37:0] gout,
                            input logic [37:0] goeb, input logic en, input logic err,
                            input int edges, input logic [31:0] hdr);
        exp_t e;
        e.side = side; e.lat = lat; e.gout = gout; e.goeb = goeb;
        e.en = en; e.err = err; e.edges = edges; e.hdr = hdr;
        sb_q.push_back(e);
    endtask

    task automatic score(input int side, input int lat, input logic [37:0] gout,
                         input logic [37:0] goeb, input logic en, input logic err,
                         input int edges, input logic [31:0] hdr);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_done actual=side%0d required=no_done", side);
            return;
        end
        e = sb_q.pop_front();
        chk("sb_side",     64'(side),  64'(e.side));
        chk("sb_latency",  64'(lat),   64'(e.lat));
        chk("sb_gpio_out", 64'(gout),  64'(e.gout));
        chk("sb_gpio_oeb", 64'(goeb),  64'(e.goeb));
        chk("sb_en",       64'(en),    64'(e.en));
        chk("sb_err",      64'(err),   64'(e.err));
        chk("sb_edges",    64'(edges), 64'(e.edges));
        chk("sb_header",   64'(hdr),   64'(e.hdr));
    endtask

    // Monitor: timestamp T0 on each chip-select fall, score on boot_done rise.
    logic csb_prev_a = 1'b1, done_prev_a = 1'b0, csb_prev_b = 1'b1, done_prev_b = 1'b0;
    int   t0_a = 0, t0_b = 0;
    always @(negedge clock) begin
        if (csb_prev_a && !csb_a) t0_a = cyc;
        if (csb_prev_b && !csb_b) t0_b = cyc;
        if (!done_prev_a && done_a)
            score(0, cyc - t0_a, gout_a, goeb_a, en_a, err_a, rise_a, hdr_a);
        if (!done_prev_b && done_b)
            score(1, cyc - t0_b, gout_b, goeb_b, en_b, err_b, rise_b, hdr_b);
        csb_prev_a  = csb_a;
        done_prev_a = done_a;
        csb_prev_b  = csb_b;
        done_prev_b = done_b;
    end

    task automatic wait_done(input int side, input int budget);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            seen = (side == 0) ? done_a : done_b;
        end
        chk("done_within_budget", 64'(seen), 64'(1));
    endtask

    // Directed stimulus sequence.
    initial begin
        int   bad;
        logic found;
        resetb_a = 1'b0; hold_a = 1'b1; resetb_b = 1'b0; hold_b = 1'b1;
        img_a = '0; img_b = '0;

        // Reset values.
        repeat (10) @(negedge clock);
        chk("rst_csb",      64'(csb_a),  64'(1));
        chk("rst_sclk",     64'(sclk_a), 64'(0));
        chk("rst_mosi",     64'(mosi_a), 64'(0));
        chk("rst_gpio_out", 64'(gout_a), 64'(0));
        chk("rst_gpio_oeb", 64'(goeb_a), 64'(38'h3F_FFFF_FFFF));
        chk("rst_en",       64'(en_a),   64'(0));
        chk("rst_done",     64'(done_a), 64'(0));
        chk("rst_err",      64'(err_a),  64'(0));

        // Hold gating.
        resetb_a = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clock);
            if (csb_a !== 1'b1) bad++;
        end
        chk("hold_gate_csb_low_cycles", 64'(bad), 64'(0));

        // Good record, D=2; hold toggled mid-transfer must be ignored.
        img_a = IMG_GOOD;
        push_exp(0, 513, 38'h2A_AAAA_AAAA, 38'h0, 1'b1, 1'b0, 128, 32'h0300_0000);
        hold_a = 1'b0;
        @(negedge clock);
        chk("csb_one_cycle_after_release", 64'(csb_a), 64'(0));
        repeat (40) @(negedge clock);
        hold_a = 1'b1;
        wait_done(0, 1200);
        hold_a = 1'b0;
        repeat (20) @(negedge clock);
        chk("done_held",      64'(done_a), 64'(1));
        chk("gpio_out_held",  64'(gout_a), 64'(38'h2A_AAAA_AAAA));
        chk("csb_after_done", 64'(csb_a),  64'(1));
        chk("edges_no_retry", 64'(rise_a), 64'(128));

        // Bad magic, boot_hold already low at reset release.
        resetb_a = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_clears_done", 64'(done_a), 64'(0));
        img_a = IMG_BAD;
        push_exp(0, 513, 38'h0, 38'h3F_FFFF_FFFF, 1'b0, 1'b1, 128, 32'h0300_0000);
        resetb_a = 1'b1;
        wait_done(0, 1200);

        // Reset during bit 50, then a clean restart.
        resetb_a = 1'b0;
        repeat (3) @(negedge clock);
        img_a = IMG_GOOD;
        push_exp(0, 513, 38'h2A_AAAA_AAAA, 38'h0, 1'b1, 1'b0, 128, 32'h0300_0000);
        resetb_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clock);
            if (!csb_a && rise_a == 50 && !sclk_a) found = 1'b1;
        end
        chk("reached_bit50", 64'(found), 64'(1));
        resetb_a = 1'b0;
        @(negedge clock);
        chk("csb_mid_reset",  64'(csb_a),  64'(1));
        chk("sclk_mid_reset", 64'(sclk_a), 64'(0));
        chk("done_mid_reset", 64'(done_a), 64'(0));
        repeat (5) @(negedge clock);
        resetb_a = 1'b1;
        wait_done(0, 1200);

        // Fast divider, non-zero boot address, mixed record bits.
        img_b = IMG_B;
        push_exp(1, 257, 38'h3F_6745_2301, 38'h03_FF00_F00F, 1'b0, 1'b0, 128, 32'h0312_3456);
        hold_b   = 1'b0;
        resetb_b = 1'b1;
        wait_done(1, 600);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
